// File: rtl/axil_cmd_arbiter.sv
// axil_cmd_arbiter
// Round-robin arbiter that shares one AXI4-Lite master command port among
// NUM_REQ requesters. One command is in flight at a time. The arbiter issues a
// single-cycle start to the master and returns completion and read data to
// the requester that won the grant. A sticky timeout flag records a late done.
module axil_cmd_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        busy,
  output logic                        timeout_err,
  output logic                        m_start,
  output logic                        m_write_en,
  output logic [ADDR_W-1:0]           m_addr,
  output logic [DATA_W-1:0]           m_wdata,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic                        m_done
);

  localparam int GW    = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // The counter saturates at its all-ones value, which is never below CNT_LAST.
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_reg;
  logic [GW-1:0]    grant_reg;
  logic [GW-1:0]    last_grant_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic [GW-1:0]     win_idx;
  logic              win_found;

  // Unpack the flat payload buses so the winner can be selected by index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin pick: lowest requester above last_grant, else lowest at/below it.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    // Wrap-around candidates first; the loop runs downward so the lowest index wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (GW'(i) <= last_grant_reg)) begin
        win_found = 1'b1;
        win_idx   = GW'(i);
      end
    end
    // Candidates after last_grant override the wrap-around choice.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (GW'(i) > last_grant_reg)) begin
        win_found = 1'b1;
        win_idx   = GW'(i);
      end
    end
  end

  // Acceptance is signalled in the same IDLE cycle that the winner is picked;
  // it is forced low while reset is asserted.
  assign req_ready  = (!rst && state_reg == IDLE && win_found) ? (ONE_HOT0 << win_idx) : '0;
  assign busy       = (state_reg != IDLE);
  assign resp_rdata = (state_reg == RESP) ? m_rdata : '0;

  // Command FSM: latch the winner, pulse start, wait for done, return the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NUM_REQ - 1);
      cnt_reg        <= '0;
      timeout_err    <= 1'b0;
      m_start        <= 1'b0;
      m_write_en     <= 1'b0;
      m_addr         <= '0;
      m_wdata        <= '0;
      resp_valid     <= '0;
    end else begin
      m_start    <= 1'b0;
      resp_valid <= '0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            m_write_en <= req_write[win_idx];
            m_addr     <= addr_arr[win_idx];
            m_wdata    <= wdata_arr[win_idx];
            grant_reg  <= win_idx;
            m_start    <= 1'b1;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (m_done) begin
            cnt_reg    <= '0;
            resp_valid <= ONE_HOT0 << grant_reg;
            state_reg  <= RESP;
          end else begin
            // The master is never aborted; the flag only records the lateness.
            if ((TIMEOUT_CYC != 0) && (cnt_reg == CNT_LAST)) begin
              timeout_err <= 1'b1;
            end
            if (cnt_reg != {CNT_W{1'b1}}) begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        RESP: begin
          last_grant_reg <= grant_reg;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_arbiter.sv
// Testbench for axil_cmd_arbiter: randomized requesters and master latency
// checked against a round-robin reference model kept in the bench.
module tb_axil_cmd_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            busy;
  logic            timeout_err;
  logic            m_start;
  logic            m_write_en;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            m_done;

  axil_cmd_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .busy(busy), .timeout_err(timeout_err),
    .m_start(m_start), .m_write_en(m_write_en), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          model_last;
  bit          model_to;
  logic [31:0] pa [N];
  logic [31:0] pd [N];
  logic        pw [N];
  logic [N-1:0] vmask;

  // Round-robin rule: first requester at or after (last+1) mod N.
  function automatic int model_pick(input logic [N-1:0] m);
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (model_last + off) % N;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] r);
    int cnt;
    int idx;
    cnt = 0;
    idx = -1;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        cnt++;
        idx = i;
      end
    end
    return (cnt == 1) ? idx : -1;
  endfunction

  task automatic drive_reqs();
    req_valid = vmask;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = pa[i];
      req_wdata[i*DW +: DW] = pd[i];
      req_write[i]          = pw[i];
    end
  endtask

  // One full transaction. Starts just before an IDLE cycle, ends at the RESP negedge.
  task automatic run_txn(input int latency, input logic [31:0] rd, input bit drop, output int obs_w);
    int           exp_w;
    int           wi;
    logic [N-1:0] exp_oh;
    @(negedge clk);
    drive_reqs();
    #1;
    exp_w  = model_pick(vmask);
    wi     = (exp_w < 0) ? 0 : exp_w;
    exp_oh = (exp_w < 0) ? '0 : (4'b0001 << exp_w);
    obs_w  = onehot_idx(req_ready);
    checks++;
    if (req_ready !== exp_oh) begin
      failures++;
      $display("FAIL req_ready got=%b exp=%b", req_ready, exp_oh);
    end
    @(negedge clk);
    checks++;
    if (m_start !== 1'b1 || busy !== 1'b1 || req_ready !== '0) begin
      failures++;
      $display("FAIL issue_ctrl got start=%b busy=%b ready=%b exp start=1 busy=1 ready=0",
               m_start, busy, req_ready);
    end
    checks++;
    if (m_addr !== pa[wi] || m_wdata !== pd[wi] || m_write_en !== pw[wi]) begin
      failures++;
      $display("FAIL issue_payload got addr=%h wdata=%h we=%b exp addr=%h wdata=%h we=%b",
               m_addr, m_wdata, m_write_en, pa[wi], pd[wi], pw[wi]);
    end
    if (drop) vmask[wi] = 1'b0;
    drive_reqs();
    for (int k = 1; k <= latency + 1; k++) begin
      @(negedge clk);
      checks++;
      if (m_start !== 1'b0 || resp_valid !== '0 || timeout_err !== (model_to || (k - 1 >= TO))) begin
        failures++;
        $display("FAIL wait_cycle%0d got start=%b resp_valid=%b to=%b exp start=0 resp_valid=0 to=%b",
                 k, m_start, resp_valid, timeout_err, (model_to || (k - 1 >= TO)));
      end
    end
    m_done  = 1'b1;
    m_rdata = rd;
    @(negedge clk);
    m_done   = 1'b0;
    model_to = model_to || (latency >= TO);
    checks++;
    if (resp_valid !== exp_oh || resp_rdata !== rd || busy !== 1'b1 || timeout_err !== model_to) begin
      failures++;
      $display("FAIL resp got valid=%b rdata=%h busy=%b to=%b exp valid=%b rdata=%h busy=1 to=%b",
               resp_valid, resp_rdata, busy, timeout_err, exp_oh, rd, model_to);
    end
    model_last = wi;
    $display("txn grant=%0d write=%0b addr=%h wdata=%h rdata=%h lat=%0d", wi, pw[wi], pa[wi], pd[wi], rd, latency);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst    = 1'b1;
    vmask  = '0;
    m_done = 1'b0;
    drive_reqs();
    @(negedge clk);
    rst        = 1'b0;
    model_last = N - 1;
    model_to   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_start !== 1'b0 || req_ready !== '0 || resp_valid !== '0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got busy=%b start=%b ready=%b resp=%b to=%b exp all 0",
               busy, m_start, req_ready, resp_valid, timeout_err);
    end
    checks++;
    if (m_addr !== '0 || m_wdata !== '0 || m_write_en !== 1'b0 || resp_rdata !== '0) begin
      failures++;
      $display("FAIL reset_data got addr=%h wdata=%h we=%b rdata=%h exp all 0",
               m_addr, m_wdata, m_write_en, resp_rdata);
    end
    rst        = 1'b0;
    model_last = N - 1;
    model_to   = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL post_reset_idle got busy=%b ready=%b exp busy=0 ready=0", busy, req_ready);
    end
  endtask

  task automatic test_single_read();
    int w;
    vmask = 4'b0100;
    pa[2] = 32'h40;
    pw[2] = 1'b0;
    pd[2] = $urandom;
    run_txn(3, 32'hDEADBEEF, 1'b1, w);
    vmask = '0;
    drive_reqs();
  endtask

  task automatic test_round_robin();
    int w;
    int exp_seq [5];
    exp_seq = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < N; i++) begin
      pa[i] = 32'h100 * i;
      pd[i] = $urandom;
      pw[i] = 1'b1;
    end
    vmask = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      run_txn(int'($urandom_range(0, 4)), $urandom, 1'b0, w);
      checks++;
      if (w !== exp_seq[t]) begin
        failures++;
        $display("FAIL rr_order%0d got=%0d exp=%0d", t, w, exp_seq[t]);
      end
    end
    vmask = '0;
    drive_reqs();
  endtask

  task automatic test_wrap_skip();
    int w;
    int exp_seq [3];
    exp_seq = '{1, 2, 1};
    vmask = 4'b1000;
    run_txn(1, $urandom, 1'b1, w);
    checks++;
    if (w !== 3) begin
      failures++;
      $display("FAIL wrap_first got=%0d exp=3", w);
    end
    vmask = 4'b0110;
    for (int t = 0; t < 3; t++) begin
      run_txn(int'($urandom_range(0, 3)), $urandom, 1'b0, w);
      checks++;
      if (w !== exp_seq[t]) begin
        failures++;
        $display("FAIL wrap_order%0d got=%0d exp=%0d", t, w, exp_seq[t]);
      end
    end
    vmask = '0;
    drive_reqs();
  endtask

  task automatic test_random();
    int           w;
    logic [N-1:0] fresh;
    for (int t = 0; t < 40; t++) begin
      fresh = N'($urandom_range(0, 15));
      if ((vmask | fresh) == '0) fresh = N'(1) << $urandom_range(0, N - 1);
      for (int i = 0; i < N; i++) begin
        if (fresh[i] && !vmask[i]) begin
          pa[i] = $urandom;
          pd[i] = $urandom;
          pw[i] = 1'($urandom_range(0, 1));
        end
      end
      vmask = vmask | fresh;
      run_txn(int'($urandom_range(0, 6)), $urandom, 1'b1, w);
    end
    vmask = '0;
    drive_reqs();
  endtask

  task automatic test_timeout();
    int w;
    vmask = 4'b0001;
    pa[0] = $urandom;
    pd[0] = $urandom;
    pw[0] = 1'b0;
    run_txn(15, $urandom, 1'b0, w);
    run_txn(20, $urandom, 1'b1, w);
    vmask = '0;
    drive_reqs();
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_sticky got to=%b busy=%b exp to=1 busy=0", timeout_err, busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    int w;
    vmask = 4'b0010;
    pa[1] = $urandom;
    pd[1] = $urandom;
    pw[1] = 1'b1;
    @(negedge clk);
    drive_reqs();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_wait_busy got=%b exp=1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || m_start !== 1'b0 || req_ready !== '0 || resp_valid !== '0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got busy=%b start=%b ready=%b resp=%b to=%b exp all 0",
               busy, m_start, req_ready, resp_valid, timeout_err);
    end
    vmask = '0;
    drive_reqs();
    @(negedge clk);
    rst        = 1'b0;
    model_last = N - 1;
    model_to   = 1'b0;
    vmask = 4'b0011;
    pa[0] = $urandom;
    pd[0] = $urandom;
    pw[0] = 1'b0;
    run_txn(2, $urandom, 1'b1, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL post_reset_priority got=%0d exp=0", w);
    end
    vmask = '0;
    drive_reqs();
  endtask

  task automatic test_idle_done();
    int w;
    @(negedge clk);
    m_done  = 1'b1;
    m_rdata = $urandom;
    @(negedge clk);
    m_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (resp_valid !== '0 || busy !== 1'b0 || m_start !== 1'b0) begin
        failures++;
        $display("FAIL idle_done%0d got resp=%b busy=%b start=%b exp all 0", k, resp_valid, busy, m_start);
      end
      @(negedge clk);
    end
    vmask = 4'b0100;
    pa[2] = $urandom;
    pd[2] = $urandom;
    pw[2] = 1'b1;
    run_txn(1, $urandom, 1'b1, w);
    checks++;
    if (w !== 2) begin
      failures++;
      $display("FAIL idle_done_after got=%0d exp=2", w);
    end
    vmask = '0;
    drive_reqs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    m_done  = 1'b0;
    m_rdata = '0;
    vmask   = '0;
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pd[i] = '0;
      pw[i] = 1'b0;
    end
    model_last = N - 1;
    model_to   = 1'b0;
    drive_reqs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_wrap_skip();
    test_random();
    test_timeout();
    test_reset_mid_wait();
    test_idle_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
